// File: rtl/debug_exec_ctrl.sv
//------------------------------------------------------------------------------
// Module   : debug_exec_ctrl
// Purpose  : Debug-panel execution controller; gates the CPU on instruction
//            boundaries from run/step, go/stop, breakpoint and SLP inputs.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module debug_exec_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             run_mode,
  input  logic             go_n,
  input  logic             stop_n,
  input  logic             bkpnt_en,
  input  logic [15:0]      bkpnt_addr,
  input  logic [15:0]      pc,
  input  logic             inst_done,
  input  logic             slp,
  output logic             cpu_en,
  output logic             running,
  output logic             bkpnt_hit,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] inst_count
);

  localparam logic [15:0]      c_cnt_last = DEBOUNCE_CYCLES - 16'd1;
  localparam logic [CNT_W-1:0] c_one      = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_BRK  = 2'b11
  } state_t;

  logic [1:0] w_btn_raw;
  logic [1:0] w_press;

  assign w_btn_raw = {stop_n, go_n};

  // Index 0 = go, index 1 = stop; both released (1) out of reset.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic        r_level_d;
    logic        r_press;
    logic [15:0] r_cnt;

    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
        r_sync1   <= 1'b1;
        r_sync2   <= 1'b1;
        r_level   <= 1'b1;
        r_level_d <= 1'b1;
        r_press   <= 1'b0;
        r_cnt     <= 16'd0;
      end else begin
        r_sync1   <= w_btn_raw[gi];
        r_sync2   <= r_sync1;
        r_level_d <= r_level;
        r_press   <= r_level_d & ~r_level;
        // Any sample matching the accepted level restarts the stability count.
        if (r_sync2 == r_level) begin
          r_cnt <= 16'd0;
        end else if (r_cnt == c_cnt_last) begin
          r_level <= r_sync2;
          r_cnt   <= 16'd0;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end

    assign w_press[gi] = r_press;
  end

  state_t           r_state;
  state_t           w_next;
  logic             r_stop_pend;
  logic             w_stop_pend_next;
  logic             r_active;
  logic             r_brk;
  logic [CNT_W-1:0] r_count;
  logic             w_go_p;
  logic             w_stop_p;
  logic             w_in_exec;
  logic             w_next_exec;
  logic             w_bk_match;

  assign w_go_p      = w_press[0];
  assign w_stop_p    = w_press[1];
  assign w_in_exec   = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_next_exec = (w_next == S_RUN) || (w_next == S_STEP);
  assign w_bk_match  = bkpnt_en && (pc == bkpnt_addr);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HALT, S_BRK: begin
        if (w_go_p && !slp) begin
          w_next = run_mode ? S_RUN : S_STEP;
        end
      end
      S_RUN: begin
        if (slp) begin
          w_next = S_HALT;
        end else if (inst_done) begin
          // A pending or coincident stop outranks a breakpoint match.
          if (r_stop_pend || w_stop_p) begin
            w_next = S_HALT;
          end else if (w_bk_match) begin
            w_next = S_BRK;
          end
        end
      end
      S_STEP: begin
        if (slp || inst_done) begin
          w_next = S_HALT;
        end
      end
      default: w_next = S_HALT;
    endcase
  end

  assign w_stop_pend_next = (w_in_exec && w_next_exec) ? (r_stop_pend | w_stop_p) : 1'b0;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_HALT;
      r_stop_pend <= 1'b0;
      r_active    <= 1'b0;
      r_brk       <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_next;
      r_stop_pend <= w_stop_pend_next;
      r_active    <= w_next_exec;
      r_brk       <= (w_next == S_BRK);
      if (inst_done && w_in_exec) begin
        r_count <= r_count + c_one;
      end
    end
  end

  assign cpu_en     = r_active;
  assign running    = r_active;
  assign bkpnt_hit  = r_brk;
  assign state      = r_state;
  assign inst_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_debug_exec_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_debug_exec_ctrl
// Purpose  : Self-checking bench for debug_exec_ctrl against a transaction model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_debug_exec_ctrl;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int SETTLE = 2 * N + 6;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic          run_mode = 1'b0;
  logic          go_n = 1'b1;
  logic          stop_n = 1'b1;
  logic          bkpnt_en = 1'b0;
  logic [15:0]   bkpnt_addr = 16'h0;
  logic [15:0]   pc = 16'h0;
  logic          inst_done = 1'b0;
  logic          slp = 1'b0;
  wire           cpu_en;
  wire           running;
  wire           bkpnt_hit;
  wire [1:0]     state;
  wire [CW-1:0]  inst_count;

  debug_exec_ctrl #(.DEBOUNCE_CYCLES(16'(N)), .CNT_W(CW)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .run_mode(run_mode), .go_n(go_n),
    .stop_n(stop_n), .bkpnt_en(bkpnt_en), .bkpnt_addr(bkpnt_addr), .pc(pc),
    .inst_done(inst_done), .slp(slp), .cpu_en(cpu_en), .running(running),
    .bkpnt_hit(bkpnt_hit), .state(state), .inst_count(inst_count)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0 halted, 1 running, 2 stepping, 3 parked at breakpoint.
  int m_mode = 0;
  bit m_pend = 0;
  int m_count = 0;

  function automatic bit m_exec();
    return (m_mode == 1) || (m_mode == 2);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string where);
    check_val({where, " state"},     32'(state),      32'(m_mode));
    check_val({where, " cpu_en"},    32'(cpu_en),     32'(m_exec()));
    check_val({where, " running"},   32'(running),    32'(m_exec()));
    check_val({where, " bkpnt_hit"}, 32'(bkpnt_hit),  32'(m_mode == 3));
    check_val({where, " count"},     32'(inst_count), 32'(m_count % (1 << CW)));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    cycles(3);
    Reset_n = 1'b1;
    cycles(1);
    m_mode = 0; m_pend = 0; m_count = 0;
  endtask

  task automatic press_go(input bit rm);
    run_mode = rm;
    go_n = 1'b0;
    cycles(SETTLE);
    go_n = 1'b1;
    cycles(SETTLE);
    if ((m_mode == 0 || m_mode == 3) && !slp) m_mode = rm ? 1 : 2;
  endtask

  task automatic press_stop();
    stop_n = 1'b0;
    cycles(SETTLE);
    stop_n = 1'b1;
    cycles(SETTLE);
    if (m_exec()) m_pend = 1;
  endtask

  task automatic glitch_go();
    go_n = 1'b0;
    cycles(2);
    go_n = 1'b1;
    cycles(SETTLE);
  endtask

  task automatic retire(input logic [15:0] pc_v);
    pc = pc_v;
    inst_done = 1'b1;
    cycles(1);
    inst_done = 1'b0;
    cycles(1);
    if (m_exec()) m_count++;
    if (m_mode == 2) begin
      m_mode = 0; m_pend = 0;
    end else if (m_mode == 1) begin
      if (m_pend) begin
        m_mode = 0; m_pend = 0;
      end else if (bkpnt_en && pc_v == bkpnt_addr) begin
        m_mode = 3;
      end
    end
  endtask

  task automatic set_slp(input bit v);
    slp = v;
    cycles(3);
    if (v && m_exec()) begin
      m_mode = 0; m_pend = 0;
    end
  endtask

  initial begin
    do_reset();
    check_all("reset");

    press_go(1'b0);
    check_all("step entry");
    retire(16'h0000);
    check_all("step retire");

    press_go(1'b1);
    for (int i = 0; i < 5; i++) retire(16'(2 + 2 * i));
    check_all("run 5 retires");
    press_stop();
    check_all("stop pending");
    retire(16'h0020);
    check_all("stop at boundary");

    bkpnt_en = 1'b1;
    bkpnt_addr = 16'h0010;
    press_go(1'b1);
    retire(16'h0010);
    check_all("bkpt hit");
    press_go(1'b1);
    check_all("bkpt resume");
    retire(16'h0012);
    check_all("after resume");

    set_slp(1'b1);
    check_all("slp halt");
    press_go(1'b1);
    check_all("go while slp");
    set_slp(1'b0);
    press_go(1'b1);
    check_all("go after slp");

    press_stop();
    retire(16'h0010);
    check_all("stop beats bkpt");
    glitch_go();
    check_all("go glitch");

    press_go(1'b1);
    for (int i = 0; i < 20; i++) retire(16'h0100);
    check_all("count wrap");

    // Asynchronous reset applied between clock edges.
    #2 Reset_n = 1'b0;
    #1;
    check_val("async cpu_en", 32'(cpu_en), 32'd0);
    check_val("async state",  32'(state),  32'd0);
    cycles(2);
    Reset_n = 1'b1;
    cycles(1);
    m_mode = 0; m_pend = 0; m_count = 0;
    check_all("post async reset");

    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 9))
        0, 1: press_go(1'($urandom_range(0, 1)));
        2:    press_stop();
        3:    glitch_go();
        4:    set_slp(1'($urandom_range(0, 3) == 0));
        5: begin
          bkpnt_en = 1'($urandom_range(0, 1));
          bkpnt_addr = 16'($urandom_range(0, 65535));
          cycles(1);
        end
        default: retire($urandom_range(0, 1) ? bkpnt_addr : 16'($urandom_range(0, 65535)));
      endcase
      check_all($sformatf("rand %0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
